// File: rtl/bp_me_burst_to_stream.sv
// BedRock Burst-to-Stream converter: one header plus N data beats in, N stream beats out with wrapped per-beat addresses.
// Optional beat-count/last checking is enabled by defining BP_ME_BURST_TO_STREAM_LAST_CHECK_EN.
module bp_me_burst_to_stream
  #(parameter int          paddr_width_p   = 40
  , parameter int          data_width_p    = 64
  , parameter int          payload_width_p = 32
  , parameter logic [15:0] payload_mask_p  = 16'h0000
  , localparam int bp_header_width_lp = 4 + 4 + paddr_width_p + 3 + payload_width_p
  )
  (input  logic                          clk_i
  , input  logic                          reset_i

  , input  logic [bp_header_width_lp-1:0] in_msg_header_i
  , input  logic                          in_msg_header_v_i
  , input  logic                          in_msg_has_data_i
  , output logic                          in_msg_header_ready_and_o

  , input  logic [data_width_p-1:0]       in_msg_data_i
  , input  logic                          in_msg_data_v_i
  , input  logic                          in_msg_last_i
  , output logic                          in_msg_data_ready_and_o

  , output logic [bp_header_width_lp-1:0] out_msg_header_o
  , output logic [data_width_p-1:0]       out_msg_data_o
  , output logic                          out_msg_v_o
  , output logic                          out_msg_last_o
  , input  logic                          out_msg_ready_and_i

  , output logic                          error_o
  );

  // Header layout, LSB first: msg_type[4], subop[4], addr, size[3], payload
  localparam int addr_lsb_lp           = 8;
  localparam int size_lsb_lp           = 8 + paddr_width_p;
  localparam int bytes_per_beat_lp     = data_width_p / 8;
  localparam int beat_offset_width_lp  = $clog2(bytes_per_beat_lp);
  localparam int max_beats_lp          = (128 > bytes_per_beat_lp) ? (128 / bytes_per_beat_lp) : 1;
  localparam int cnt_width_lp          = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

  typedef enum logic [1:0] {
    e_ready  = 2'd0,
    e_nodata = 2'd1,
    e_data   = 2'd2
  } state_e;

  state_e                          state_r;
  logic [bp_header_width_lp-1:0]   header_r;
  logic [cnt_width_lp-1:0]         cnt_r;

  logic                            has_data_in_s;
  logic                            header_hs_s;
  logic                            data_hs_s;
  logic [2:0]                      size_s;
  logic                            size_gt_beat_s;
  logic [paddr_width_p-1:0]        base_addr_s;
  logic [paddr_width_p-1:0]        offset_s;
  logic [paddr_width_p-1:0]        size_mask_s;
  logic [paddr_width_p-1:0]        beat_addr_s;

  assign has_data_in_s = payload_mask_p[in_msg_header_i[3:0]];
  assign header_hs_s   = (state_r == e_ready) & in_msg_header_v_i;
  assign data_hs_s     = (state_r == e_data) & in_msg_data_v_i & out_msg_ready_and_i;

  // Per-beat address: wrap the low msg_size bits within the size-aligned block
  always_comb begin
    size_s         = header_r[size_lsb_lp +: 3];
    base_addr_s    = header_r[addr_lsb_lp +: paddr_width_p];
    size_gt_beat_s = ({29'b0, size_s} > 32'(beat_offset_width_lp));
    offset_s       = paddr_width_p'(cnt_r) << beat_offset_width_lp;
    size_mask_s    = (paddr_width_p'(1'b1) << size_s) - paddr_width_p'(1'b1);
    if (size_gt_beat_s) begin
      beat_addr_s = (base_addr_s & ~size_mask_s) | ((base_addr_s + offset_s) & size_mask_s);
    end else begin
      beat_addr_s = base_addr_s;
    end
  end

  // Output decode from the registered state
  always_comb begin
    in_msg_header_ready_and_o = 1'b0;
    in_msg_data_ready_and_o   = 1'b0;
    out_msg_v_o               = 1'b0;
    out_msg_last_o            = 1'b0;
    out_msg_data_o            = '0;
    out_msg_header_o          = header_r;
    out_msg_header_o[addr_lsb_lp +: paddr_width_p] = beat_addr_s;
    case (state_r)
      e_ready: begin
        in_msg_header_ready_and_o = 1'b1;
      end
      e_nodata: begin
        out_msg_v_o    = 1'b1;
        out_msg_last_o = 1'b1;
      end
      e_data: begin
        out_msg_v_o             = in_msg_data_v_i;
        in_msg_data_ready_and_o = out_msg_ready_and_i;
        out_msg_data_o          = in_msg_data_i;
        out_msg_last_o          = in_msg_last_i;
      end
      default: begin
        out_msg_v_o = 1'b0;
      end
    endcase
  end

  // Message FSM: latch header, then stream either one zero beat or the data beats
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_ready;
      cnt_r    <= '0;
      header_r <= '0;
    end else begin
      case (state_r)
        e_ready: begin
          if (in_msg_header_v_i) begin
            header_r <= in_msg_header_i;
            cnt_r    <= '0;
            state_r  <= has_data_in_s ? e_data : e_nodata;
          end
        end
        e_nodata: begin
          if (out_msg_ready_and_i) begin
            state_r <= e_ready;
          end
        end
        e_data: begin
          if (in_msg_data_v_i & out_msg_ready_and_i) begin
            cnt_r <= cnt_r + cnt_width_lp'(1'b1);
            if (in_msg_last_i) begin
              state_r <= e_ready;
            end
          end
        end
        default: begin
          state_r <= e_ready;
        end
      endcase
    end
  end

`ifdef BP_ME_BURST_TO_STREAM_LAST_CHECK_EN
  logic                    error_r;
  logic [cnt_width_lp-1:0] last_cnt_s;

  // Index of the final beat for the latched message size
  always_comb begin
    if (size_gt_beat_s) begin
      last_cnt_s = cnt_width_lp'((32'd1 << ({29'b0, size_s} - 32'(beat_offset_width_lp))) - 32'd1);
    end else begin
      last_cnt_s = '0;
    end
  end

  // Sticky error on a misplaced last or a has_data hint that disagrees with the mask
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (data_hs_s & (in_msg_last_i != (cnt_r == last_cnt_s))) begin
      error_r <= 1'b1;
    end else if (header_hs_s & (in_msg_has_data_i != has_data_in_s)) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign error_o = error_r;
`else
  logic unused_s;
  assign unused_s = in_msg_has_data_i ^ header_hs_s ^ data_hs_s;
  assign error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_burst_to_stream.sv
// Directed and randomized-backpressure bench for bp_me_burst_to_stream (64-bit data, types 1 and 2 carry data).
module tb_bp_me_burst_to_stream;

  localparam int          paddr_width_p   = 40;
  localparam int          data_width_p    = 64;
  localparam int          payload_width_p = 32;
  localparam logic [15:0] payload_mask_p  = 16'h0006;
  localparam int          hdr_w           = 4 + 4 + paddr_width_p + 3 + payload_width_p;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [hdr_w-1:0]  in_msg_header_i;
  logic              in_msg_header_v_i;
  logic              in_msg_has_data_i;
  logic              in_msg_header_ready_and_o;
  logic [63:0]       in_msg_data_i;
  logic              in_msg_data_v_i;
  logic              in_msg_last_i;
  logic              in_msg_data_ready_and_o;
  logic [hdr_w-1:0]  out_msg_header_o;
  logic [63:0]       out_msg_data_o;
  logic              out_msg_v_o;
  logic              out_msg_last_o;
  logic              out_msg_ready_and_i;
  logic              error_o;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_addr [0:15];

  bp_me_burst_to_stream #(
    .paddr_width_p(paddr_width_p), .data_width_p(data_width_p),
    .payload_width_p(payload_width_p), .payload_mask_p(payload_mask_p)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_msg_header_i(in_msg_header_i), .in_msg_header_v_i(in_msg_header_v_i),
    .in_msg_has_data_i(in_msg_has_data_i), .in_msg_header_ready_and_o(in_msg_header_ready_and_o),
    .in_msg_data_i(in_msg_data_i), .in_msg_data_v_i(in_msg_data_v_i),
    .in_msg_last_i(in_msg_last_i), .in_msg_data_ready_and_o(in_msg_data_ready_and_o),
    .out_msg_header_o(out_msg_header_o), .out_msg_data_o(out_msg_data_o),
    .out_msg_v_o(out_msg_v_o), .out_msg_last_o(out_msg_last_o),
    .out_msg_ready_and_i(out_msg_ready_and_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  function automatic logic [hdr_w-1:0] make_hdr(input logic [3:0] t, input logic [3:0] sub,
                                                input logic [39:0] a, input logic [2:0] s,
                                                input logic [31:0] p);
    return {p, s, a, sub, t};
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    reset_i = 1'b1; in_msg_header_v_i = 1'b0; in_msg_data_v_i = 1'b0; in_msg_last_i = 1'b0;
    in_msg_header_i = '0; in_msg_data_i = '0; in_msg_has_data_i = 1'b0; out_msg_ready_and_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset_i = 1'b0; #1;
    checks++; if (in_msg_header_ready_and_o !== 1'b1) begin errors++; $display("FAIL reset_hdr_ready: got %b expected 1", in_msg_header_ready_and_o); end
    checks++; if (in_msg_data_ready_and_o !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", in_msg_data_ready_and_o); end
    checks++; if (out_msg_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b expected 0", out_msg_v_o); end
    checks++; if (out_msg_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_msg_last_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_o); end
  endtask

  task automatic test_nodata();
    logic [hdr_w-1:0] h;
    h = make_hdr(4'h0, 4'h5, 40'h12_3456_7890, 3'd6, 32'hCAFE_F00D);
    @(posedge clk); #1;
    in_msg_header_i = h; in_msg_header_v_i = 1'b1; in_msg_has_data_i = 1'b0; out_msg_ready_and_i = 1'b1; #1;
    checks++; if (out_msg_v_o !== 1'b0) begin errors++; $display("FAIL nodata_v_c0: got %b expected 0", out_msg_v_o); end
    @(posedge clk); #1;
    in_msg_header_v_i = 1'b0; in_msg_header_i = ~h; #1;
    checks++; if (out_msg_v_o !== 1'b1) begin errors++; $display("FAIL nodata_v: got %b expected 1", out_msg_v_o); end
    checks++; if (out_msg_last_o !== 1'b1) begin errors++; $display("FAIL nodata_last: got %b expected 1", out_msg_last_o); end
    checks++; if (out_msg_data_o !== 64'h0) begin errors++; $display("FAIL nodata_data: got %h expected 0", out_msg_data_o); end
    checks++; if (out_msg_header_o !== h) begin errors++; $display("FAIL nodata_hdr: got %h expected %h", out_msg_header_o, h); end
    checks++; if (in_msg_header_ready_and_o !== 1'b0) begin errors++; $display("FAIL nodata_busy_ready: got %b expected 0", in_msg_header_ready_and_o); end
    @(posedge clk); #1; #1;
    checks++; if (in_msg_header_ready_and_o !== 1'b1) begin errors++; $display("FAIL nodata_ready_c2: got %b expected 1", in_msg_header_ready_and_o); end
    checks++; if (out_msg_v_o !== 1'b0) begin errors++; $display("FAIL nodata_v_c2: got %b expected 0", out_msg_v_o); end
  endtask

  // Sends one data message; expected addresses come from exp_addr[].
  task automatic run_data_msg(input logic [3:0] mtype, input logic [39:0] addr, input logic [2:0] size,
                              input logic [31:0] payload, input int nbeats, input bit rnd,
                              input logic [63:0] seed);
    logic [hdr_w-1:0] h, eh;
    int oi, cyc;
    bit dv, rdy;
    h = make_hdr(mtype, 4'hA, addr, size, payload);
    @(posedge clk); #1;
    in_msg_header_i = h; in_msg_header_v_i = 1'b1; in_msg_has_data_i = 1'b1; in_msg_data_v_i = 1'b0; #1;
    checks++; if (in_msg_header_ready_and_o !== 1'b1) begin errors++; $display("FAIL msg_hdr_ready: got %b expected 1", in_msg_header_ready_and_o); end
    @(posedge clk); #1;
    in_msg_header_v_i = 1'b0; in_msg_header_i = ~h;
    oi = 0; cyc = 0;
    while (oi < nbeats && cyc < 400) begin
      dv  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      in_msg_data_v_i = dv; in_msg_data_i = seed + 64'(oi);
      in_msg_last_i = (oi == nbeats - 1); out_msg_ready_and_i = rdy;
      #1;
      checks++; if (out_msg_v_o !== dv) begin errors++; $display("FAIL beat_v: got %b expected %b", out_msg_v_o, dv); end
      checks++; if (in_msg_data_ready_and_o !== rdy) begin errors++; $display("FAIL beat_data_ready: got %b expected %b", in_msg_data_ready_and_o, rdy); end
      checks++; if (in_msg_header_ready_and_o !== 1'b0) begin errors++; $display("FAIL beat_hdr_ready: got %b expected 0", in_msg_header_ready_and_o); end
      if (dv && rdy) begin
        eh = make_hdr(mtype, 4'hA, exp_addr[oi], size, payload);
        checks++; if (out_msg_header_o !== eh) begin errors++; $display("FAIL beat%0d_hdr: got %h expected %h", oi, out_msg_header_o, eh); end
        checks++; if (out_msg_data_o !== seed + 64'(oi)) begin errors++; $display("FAIL beat%0d_data: got %h expected %h", oi, out_msg_data_o, seed + 64'(oi)); end
        checks++; if (out_msg_last_o !== (oi == nbeats - 1)) begin errors++; $display("FAIL beat%0d_last: got %b expected %b", oi, out_msg_last_o, (oi == nbeats - 1)); end
        oi++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    in_msg_data_v_i = 1'b0; in_msg_last_i = 1'b0; #1;
    checks++; if (oi !== nbeats) begin errors++; $display("FAIL msg_beat_count: got %0d expected %0d", oi, nbeats); end
    checks++; if (in_msg_header_ready_and_o !== 1'b1) begin errors++; $display("FAIL msg_done_ready: got %b expected 1", in_msg_header_ready_and_o); end
    checks++; if (out_msg_v_o !== 1'b0) begin errors++; $display("FAIL msg_done_v: got %b expected 0", out_msg_v_o); end
  endtask

  task automatic test_burst_aligned();
    logic [39:0] t [0:7] = '{40'h80, 40'h88, 40'h90, 40'h98, 40'hA0, 40'hA8, 40'hB0, 40'hB8};
    for (int i = 0; i < 8; i++) exp_addr[i] = t[i];
    run_data_msg(4'h1, 40'h80, 3'd6, 32'h1111_2222, 8, 1'b0, 64'hD000_0000_0000_0000);
  endtask

  task automatic test_burst_wrap();
    logic [39:0] t [0:7] = '{40'h98, 40'hA0, 40'hA8, 40'hB0, 40'hB8, 40'h80, 40'h88, 40'h90};
    for (int i = 0; i < 8; i++) exp_addr[i] = t[i];
    run_data_msg(4'h2, 40'h98, 3'd6, 32'h3333_4444, 8, 1'b0, 64'hA5A5_0000_0000_0100);
  endtask

  task automatic test_back_to_back();
    exp_addr[0] = 40'h00_0000_1003;
    run_data_msg(4'h1, 40'h00_0000_1003, 3'd2, 32'h0000_0004, 1, 1'b0, 64'h4444);
    exp_addr[0] = 40'h00_0000_2010; exp_addr[1] = 40'h00_0000_2018;
    run_data_msg(4'h2, 40'h00_0000_2010, 3'd4, 32'h0000_0010, 2, 1'b0, 64'h1600);
  endtask

  task automatic test_random_backpressure();
    logic [39:0] a, msg_bytes, base;
    logic [2:0]  s;
    int n;
    for (int m = 0; m < 100; m++) begin
      s = 3'($urandom_range(0, 7));
      a = {8'h00, 32'($urandom)};
      msg_bytes = 40'd1 << s;
      n = (s > 3'd3) ? (1 << (s - 3'd3)) : 1;
      base = a - (a % msg_bytes);
      for (int i = 0; i < n; i++)
        exp_addr[i] = (msg_bytes <= 40'd8) ? a : base + ((a % msg_bytes + 40'(8 * i)) % msg_bytes);
      run_data_msg((m % 2 == 0) ? 4'h1 : 4'h2, a, s, 32'($urandom), n, 1'b1, {32'($urandom), 32'(m << 8)});
    end
  endtask

  task automatic test_reset_mid_message();
    @(posedge clk); #1;
    in_msg_header_i = make_hdr(4'h1, 4'h0, 40'h80, 3'd6, 32'h0); in_msg_header_v_i = 1'b1; in_msg_has_data_i = 1'b1;
    @(posedge clk); #1;
    in_msg_header_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_msg_data_v_i = 1'b1; in_msg_data_i = 64'(i); in_msg_last_i = 1'b0; out_msg_ready_and_i = 1'b1;
      @(posedge clk); #1;
    end
    reset_i = 1'b1; in_msg_data_v_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0; in_msg_data_v_i = 1'b1; #1;
    checks++; if (out_msg_v_o !== 1'b0) begin errors++; $display("FAIL rst_mid_v: got %b expected 0", out_msg_v_o); end
    checks++; if (in_msg_header_ready_and_o !== 1'b1) begin errors++; $display("FAIL rst_mid_hdr_ready: got %b expected 1", in_msg_header_ready_and_o); end
    checks++; if (in_msg_data_ready_and_o !== 1'b0) begin errors++; $display("FAIL rst_mid_data_ready: got %b expected 0", in_msg_data_ready_and_o); end
    in_msg_data_v_i = 1'b0;
    exp_addr[0] = 40'h00_DEAD_BEE8;
    run_data_msg(4'h2, 40'h00_DEAD_BEE8, 3'd3, 32'h0000_0008, 1, 1'b0, 64'hFEED_0000_0000_0008);
  endtask

`ifdef BP_ME_BURST_TO_STREAM_LAST_CHECK_EN
  task automatic test_last_check();
    @(posedge clk); #1;
    in_msg_header_i = make_hdr(4'h1, 4'h0, 40'h100, 3'd6, 32'h0); in_msg_header_v_i = 1'b1; in_msg_has_data_i = 1'b1;
    @(posedge clk); #1;
    in_msg_header_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_msg_data_v_i = 1'b1; in_msg_data_i = 64'(i); in_msg_last_i = (i == 3); out_msg_ready_and_i = 1'b1; #1;
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL lastchk_pre%0d: got %b expected 0", i, error_o); end
      @(posedge clk); #1;
    end
    in_msg_data_v_i = 1'b0; in_msg_last_i = 1'b0; #1;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL lastchk_set: got %b expected 1", error_o); end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL lastchk_sticky: got %b expected 1", error_o); end
    test_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_nodata();
    test_burst_aligned();
    test_burst_wrap();
    test_back_to_back();
    test_random_backpressure();
    test_reset_mid_message();
`ifdef BP_ME_BURST_TO_STREAM_LAST_CHECK_EN
    test_last_check();
`endif
    #1;
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL final_error: got %b expected 0", error_o); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
